bfly4_2d_sched: RTL and testbench
=================================

BFLY4_2D_SCHED -- requirements
Module: bfly4_2d_sched

Interface
REQ-001 SHALL have parameter IN_W, default 19, giving the signed width of input samples.
REQ-002 SHALL have parameter OUT_W, fixed as IN_W+2 (default 21), giving the signed width of output samples.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning a row is presented on in_0..in_3.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a row this cycle.
REQ-007 SHALL have ports in_0, in_1, in_2 and in_3, input, IN_W signed each, the four samples of the current row.
REQ-008 SHALL have port out_valid, output, 1, meaning out_0..out_3 hold a valid transformed column.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts the column this cycle.
REQ-010 SHALL have ports out_0, out_1, out_2 and out_3, output, OUT_W signed each, the column butterfly results.
REQ-011 SHALL have port out_col, output, 2, the index (0..3) of the column currently presented.
REQ-012 SHALL have port out_last, output, 1, asserted together with out_valid when out_col==3.

Function
REQ-013 SHALL time-share one 4-point butterfly network, with IN_W+1 inputs and OUT_W outputs, between the row pass and the column pass.
- Network outputs: o0=a0+a3, o1=a1+a2, o2=a1-a2, o3=a0-a3.
- Full-precision, sign-extended arithmetic; no saturation and no rounding.
REQ-014 SHALL implement a three-state FSM with states IDLE, LOAD and EMIT.
REQ-015 SHALL drive in_ready=1 in IDLE and LOAD, and in_ready=0 in EMIT.
REQ-016 SHALL treat a row as accepted only on a cycle where in_valid && in_ready.
REQ-017 SHALL handle each accepted row r as follows:
- Sign-extend in_0..in_3 to IN_W+1 bits.
- Pass them through the network.
- Store the four IN_W+1-bit results, truncated from the OUT_W network output, in buffer row r: buf[r][0..3].
- r is the 2-bit row counter row_cnt.
REQ-018 SHALL transition IDLE->LOAD on the first accepted row, and increment row_cnt on every accepted row.
REQ-019 SHALL transition LOAD->EMIT on the cycle the row with row_cnt==3 is accepted, and wrap row_cnt to 0 at that point.
REQ-020 SHALL hold state, counters and buffer in IDLE or LOAD when no row is accepted; bubbles between rows are allowed.
REQ-021 SHALL, in EMIT, drive out_valid=1 and present column c=col_cnt:
- Network inputs a0..a3 = buf[0][c], buf[1][c], buf[2][c], buf[3][c].
- out_0..out_3 = o0..o3, decoded combinationally from registered buffer state.
- out_col = col_cnt.
REQ-022 SHALL make the first out_valid cycle the cycle immediately after the fourth row is accepted (latency 1 cycle).
REQ-023 SHALL increment col_cnt on each cycle where out_valid && out_ready.
REQ-024 SHALL hold out_* and col_cnt stable while out_valid && !out_ready.
REQ-025 SHALL, on out_valid && out_ready with col_cnt==3, wrap col_cnt to 0 and transition EMIT->IDLE.
REQ-026 SHALL make the minimum block period 8 cycles: 4 load cycles plus 4 emit cycles with no stalls.
REQ-027 SHALL ignore in_valid during EMIT; the rows presented then are not consumed.
REQ-028 SHALL drive out_valid=0 and out_last=0 outside EMIT.
REQ-029 SHALL NOT overwrite the buffer during EMIT.

Reset
REQ-030 SHALL, while rst=1 on a clock edge, set the state to IDLE, row_cnt=0, col_cnt=0 and all buffer entries to 0, overriding any handshake in that cycle.
REQ-031 SHALL produce the following output values after reset: out_valid=0, out_last=0, out_col=0, out_0..out_3=0 and in_ready=1.
REQ-032 SHALL, on reset mid-LOAD or mid-EMIT, discard the partial block; the next accepted row SHALL be stored as row 0.

Verification
REQ-033 SHALL cover: four rows of all-ones, out_ready=1 -> columns 0,1 = (4,4,0,0) and columns 2,3 = (0,0,0,0); out_valid on cycles 5-8; out_last on cycle 8.
REQ-034 SHALL cover: all samples = 262143 -> column 0 = (1048572,1048572,0,0); all samples = -262144 -> column 0 = (-1048576,-1048576,0,0); no overflow.
REQ-035 SHALL cover: out_ready=0 for 3 cycles on column 1 -> out_col=1 and data held constant for 3 cycles; then col 2 and col 3 follow with no loss.
REQ-036 SHALL cover: in_valid held high through EMIT -> in_ready=0 for exactly 4 cycles and the next block starts with the row present on the cycle after out_last handshake.
REQ-037 SHALL cover: rst pulsed after 2 rows accepted -> no out_valid; 4 new rows then produce the result of the new rows only.
REQ-038 SHALL cover: in_valid gaps of 1-3 cycles between rows -> results identical to back-to-back input.

Source files
------------

// File: rtl/bfly4_2d_sched.sv
// 4x4 two-pass (row then column) radix-4 butterfly transform with one shared
// butterfly network, a 4x4 row buffer and valid/ready handshakes on both sides.
module bfly4_2d_sched #(
    parameter  int IN_W  = 19,
    localparam int OUT_W = IN_W + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_0,
    input  logic signed [IN_W-1:0]  in_1,
    input  logic signed [IN_W-1:0]  in_2,
    input  logic signed [IN_W-1:0]  in_3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_0,
    output logic signed [OUT_W-1:0] out_1,
    output logic signed [OUT_W-1:0] out_2,
    output logic signed [OUT_W-1:0] out_3,
    output logic [1:0]              out_col,
    output logic                    out_last
);

    localparam int BW = IN_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_row_cnt;
    logic [1:0]            r_col_cnt;
    logic signed [BW-1:0]  r_buf [4][4];

    logic                  w_accept;
    logic                  w_out_fire;
    logic signed [BW-1:0]  w_a [4];
    logic signed [OUT_W-1:0] w_o [4];

    function automatic logic signed [OUT_W-1:0] sx(input logic signed [BW-1:0] v);
        return {v[BW-1], v};
    endfunction

    // Shared network: fed by the incoming row while loading, by a buffered column in EMIT.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            w_a[k] = r_buf[k][r_col_cnt];
        end
        if (r_state != EMIT) begin
            w_a[0] = {in_0[IN_W-1], in_0};
            w_a[1] = {in_1[IN_W-1], in_1};
            w_a[2] = {in_2[IN_W-1], in_2};
            w_a[3] = {in_3[IN_W-1], in_3};
        end
        w_o[0] = sx(w_a[0]) + sx(w_a[3]);
        w_o[1] = sx(w_a[1]) + sx(w_a[2]);
        w_o[2] = sx(w_a[1]) - sx(w_a[2]);
        w_o[3] = sx(w_a[0]) - sx(w_a[3]);
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b1;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) w_state_nxt = LOAD;
            end
            LOAD: begin
                if (in_valid && r_row_cnt == 2'd3) w_state_nxt = EMIT;
            end
            EMIT: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                out_last  = (r_col_cnt == 2'd3);
                if (out_ready && r_col_cnt == 2'd3) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_row_cnt <= '0;
            r_col_cnt <= '0;
            for (int unsigned r = 0; r < 4; r++) begin
                for (int unsigned c = 0; c < 4; c++) begin
                    r_buf[r][c] <= '0;
                end
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_row_cnt <= r_row_cnt + 2'd1;
                // Row results always fit in BW bits, so dropping the top bit is lossless.
                for (int unsigned c = 0; c < 4; c++) begin
                    r_buf[r_row_cnt][c] <= w_o[c][BW-1:0];
                end
            end
            if (w_out_fire) begin
                r_col_cnt <= r_col_cnt + 2'd1;
            end
        end
    end

    assign out_col = r_col_cnt;
    assign out_0   = (r_state == EMIT) ? w_o[0] : '0;
    assign out_1   = (r_state == EMIT) ? w_o[1] : '0;
    assign out_2   = (r_state == EMIT) ? w_o[2] : '0;
    assign out_3   = (r_state == EMIT) ? w_o[3] : '0;

endmodule

// File: tb/tb_bfly4_2d_sched.sv
// Directed self-checking bench for bfly4_2d_sched with hand-computed column results.
module tb_bfly4_2d_sched;

    localparam int IN_W  = 19;
    localparam int OUT_W = IN_W + 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_0, in_1, in_2, in_3;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_0, out_1, out_2, out_3;
    logic [1:0]              out_col;
    logic                    out_last;

    int checks   = 0;
    int failures = 0;

    // rows_m[row][sample]; exp_mat[col][out] worked out by hand from rows_m
    int rows_m [4][4] = '{'{1, 2, 3, 4}, '{-5, 6, -7, 8}, '{10, 0, 0, -10}, '{3, 3, 3, 3}};
    int exp_mat[4][4] = '{'{11, 3, 3, -1}, '{11, -1, -1, -1}, '{-1, 13, 13, -1}, '{-3, 7, -33, -3}};
    int exp_m  [4][4];

    bfly4_2d_sched #(.IN_W(IN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_0      (in_0),
        .in_1      (in_1),
        .in_2      (in_2),
        .in_3      (in_3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_0     (out_0),
        .out_1     (out_1),
        .out_2     (out_2),
        .out_3     (out_3),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int a, input int b, input int c, input int d);
        in_0 = IN_W'(a);
        in_1 = IN_W'(b);
        in_2 = IN_W'(c);
        in_3 = IN_W'(d);
    endtask

    task automatic load_row(input int a, input int b, input int c, input int d, input string tag);
        in_valid = 1'b1;
        set_row(a, b, c, d);
        #1;
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_no_valid"}, int'(out_valid), 0);
        tick();
    endtask

    task automatic set_uniform_exp(input int v);
        for (int c = 0; c < 4; c++) begin
            exp_m[c] = (c < 2) ? '{4 * v, 4 * v, 0, 0} : '{0, 0, 0, 0};
        end
    endtask

    task automatic load_uniform(input int v, input bit hold, input string tag);
        for (int r = 0; r < 4; r++) load_row(v, v, v, v, tag);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic load_m(input bit gaps, input string tag);
        for (int r = 0; r < 4; r++) begin
            if (gaps && r > 0) begin
                for (int g = 0; g < r; g++) begin
                    in_valid = 1'b0;
                    #1;
                    chk({tag, "_gap_no_valid"}, int'(out_valid), 0);
                    tick();
                end
            end
            load_row(rows_m[r][0], rows_m[r][1], rows_m[r][2], rows_m[r][3], tag);
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_col(input int c, input string tag);
        #1;
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_col"}, int'(out_col), c);
        chk({tag, "_last"}, int'(out_last), (c == 3) ? 1 : 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_o0"}, int'(out_0), exp_m[c][0]);
        chk({tag, "_o1"}, int'(out_1), exp_m[c][1]);
        chk({tag, "_o2"}, int'(out_2), exp_m[c][2]);
        chk({tag, "_o3"}, int'(out_3), exp_m[c][3]);
    endtask

    task automatic emit_all(input int stall_col, input int stall_n, input string tag);
        for (int c = 0; c < 4; c++) begin
            if (c == stall_col) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk_col(c, {tag, "_stall"});
                    tick();
                end
            end
            out_ready = 1'b1;
            chk_col(c, tag);
            tick();
        end
        #1;
        chk({tag, "_done_valid"}, int'(out_valid), 0);
        chk({tag, "_done_last"}, int'(out_last), 0);
        chk({tag, "_done_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        set_row(7, 7, 7, 7);
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_col", int'(out_col), 0);
        chk("rst_out_0", int'(out_0), 0);
        chk("rst_out_3", int'(out_3), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        set_uniform_exp(1);
        load_uniform(1, 1'b0, "ones_load");
        emit_all(-1, 0, "ones");

        set_uniform_exp(262143);
        load_uniform(262143, 1'b0, "maxp_load");
        emit_all(-1, 0, "maxp");

        set_uniform_exp(-262144);
        load_uniform(-262144, 1'b0, "maxn_load");
        emit_all(-1, 0, "maxn");

        exp_m = exp_mat;
        load_m(1'b0, "stall_load");
        emit_all(1, 3, "stallblk");

        set_uniform_exp(1);
        load_uniform(1, 1'b1, "hold_load");
        set_row(rows_m[0][0], rows_m[0][1], rows_m[0][2], rows_m[0][3]);
        emit_all(-1, 0, "hold");
        exp_m = exp_mat;
        load_m(1'b0, "hold_next_load");
        emit_all(-1, 0, "hold_next");

        load_row(50, -50, 50, -50, "junk_load");
        load_row(50, 50, 50, 50, "junk_load");
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstload_valid", int'(out_valid), 0);
        chk("rstload_in_ready", int'(in_ready), 1);
        load_m(1'b0, "after_rst_load");
        emit_all(-1, 0, "after_rst");

        set_uniform_exp(1);
        load_uniform(1, 1'b0, "emitrst_load");
        out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstemit_valid", int'(out_valid), 0);
        chk("rstemit_col", int'(out_col), 0);
        chk("rstemit_o0", int'(out_0), 0);
        chk("rstemit_in_ready", int'(in_ready), 1);

        exp_m = exp_mat;
        load_m(1'b1, "gap_load");
        emit_all(-1, 0, "gap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
